fp_addsub_req_ctrl: RTL and testbench

- Request-side controller for the floating-point add/sub datapath, sitting between a client and the adder.
- Accepts one IEEE 754 operation (a, b, operation_select) over a valid/ready handshake and drives registered operands into the adder.
- Counts the adder's fixed latency, captures the packed result, and returns it over a valid/ready response channel.
- Resolves NaN/Inf operand cases itself, without using the adder.

---
 rtl/fp_addsub_req_ctrl_pkg.sv | 23 ++
 rtl/fp_special_detect.sv | 58 +++++
 rtl/fp_addsub_req_ctrl.sv | 123 ++++++++++++
 tb/tb_fp_addsub_req_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_req_ctrl_pkg.sv
// Shared types and constants for the FP add/sub request controller and its
// special-operand detector.
package fp_addsub_req_ctrl_pkg;

    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;
    localparam int CNT_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ctrl_state_t;

    localparam logic [31:0]         QNAN         = 32'h7FC0_0000;
    localparam logic [EXP_BITS-1:0] EXP_ALL_ONES = '1;

    // Bit positions inside rsp_flags
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_ZERO     = 0;

endpackage

// File: rtl/fp_special_detect.sv
// Combinational NaN/Inf classifier: decides whether an add/sub can be resolved
// without the adder and, if so, what the result is.
module fp_special_detect
    import fp_addsub_req_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             is_bypass,
    output logic [WIDTH-1:0] bypass_value
);

    localparam int SIGN = WIDTH - 1;

    logic [EXP_BITS-1:0]  exp_a;
    logic [EXP_BITS-1:0]  exp_b;
    logic [MANT_BITS-1:0] mant_a;
    logic [MANT_BITS-1:0] mant_b;
    logic                 a_nan;
    logic                 b_nan;
    logic                 a_inf;
    logic                 b_inf;
    logic                 eff_sub;

    assign exp_a  = a[SIGN-1 -: EXP_BITS];
    assign exp_b  = b[SIGN-1 -: EXP_BITS];
    assign mant_a = a[MANT_BITS-1:0];
    assign mant_b = b[MANT_BITS-1:0];

    assign a_nan   = (exp_a == EXP_ALL_ONES) && (mant_a != '0);
    assign b_nan   = (exp_b == EXP_ALL_ONES) && (mant_b != '0);
    assign a_inf   = (exp_a == EXP_ALL_ONES) && (mant_a == '0);
    assign b_inf   = (exp_b == EXP_ALL_ONES) && (mant_b == '0);
    assign eff_sub = a[SIGN] ^ b[SIGN] ^ op;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        is_bypass    = 1'b0;
        bypass_value = '0;
        if (a_nan || b_nan) begin
            is_bypass    = 1'b1;
            bypass_value = WIDTH'(QNAN);
        end else if (a_inf && b_inf) begin
            is_bypass    = 1'b1;
            bypass_value = eff_sub ? WIDTH'(QNAN) : a;
        end else if (a_inf) begin
            is_bypass    = 1'b1;
            bypass_value = a;
        end else if (b_inf) begin
            // Subtraction flips the sign of the infinite subtrahend
            is_bypass    = 1'b1;
            bypass_value = {b[SIGN] ^ op, EXP_ALL_ONES, {MANT_BITS{1'b0}}};
        end
    end

endmodule

// File: rtl/fp_addsub_req_ctrl.sv
// Request/response controller in front of a fixed-latency FP adder.
// Optional exception flags output enabled by defining FP_EXC_FLAGS_EN.
module fp_addsub_req_ctrl
    import fp_addsub_req_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_op,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_op,
    input  logic [WIDTH-1:0] adder_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_special,
    output logic             busy
`ifdef FP_EXC_FLAGS_EN
    ,
    output logic [2:0]       rsp_flags
`endif
);

    ctrl_state_t         state;
    logic [CNT_BITS-1:0] counter;
    logic                is_bypass;
    logic [WIDTH-1:0]    bypass_value;

    fp_special_detect #(
        .WIDTH(WIDTH)
    ) u_special (
        .a           (req_a),
        .b           (req_b),
        .op          (req_op),
        .is_bypass   (is_bypass),
        .bypass_value(bypass_value)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef FP_EXC_FLAGS_EN
    // The only bypass result that is a NaN is the invalid-operation qNaN
    logic [2:0] bypass_flags;
    logic [2:0] normal_flags;

    always_comb begin
        bypass_flags                = '0;
        bypass_flags[FLAG_INVALID]  = (bypass_value == WIDTH'(QNAN));
        normal_flags                = '0;
        normal_flags[FLAG_OVERFLOW] = (adder_result[WIDTH-2 -: EXP_BITS] == EXP_ALL_ONES);
        normal_flags[FLAG_ZERO]     = (adder_result[WIDTH-2:0] == '0);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            adder_a     <= '0;
            adder_b     <= '0;
            adder_op    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_special <= 1'b0;
`ifdef FP_EXC_FLAGS_EN
            rsp_flags   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        adder_a  <= req_a;
                        adder_b  <= req_b;
                        adder_op <= req_op;
                        if (is_bypass) begin
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_result  <= bypass_value;
                            rsp_special <= 1'b1;
`ifdef FP_EXC_FLAGS_EN
                            rsp_flags   <= bypass_flags;
`endif
                        end else begin
                            state   <= WAIT;
                            counter <= CNT_BITS'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge that sees the settled adder output
                    if (counter == '0) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= adder_result;
                        rsp_special <= 1'b0;
`ifdef FP_EXC_FLAGS_EN
                        rsp_flags   <= normal_flags;
`endif
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_req_ctrl.sv
// Bench for fp_addsub_req_ctrl: three instances (LATENCY 0, 2, 3) behind a
// stub adder, scoreboard per instance, vector table plus timing sequences.
module tb_fp_addsub_req_ctrl;

    localparam int N = 3;   // index 0: LATENCY=0, 1: LATENCY=2, 2: LATENCY=3

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        special;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        special;
        logic [2:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_op;
    logic        req_valid    [N];
    logic        req_ready    [N];
    logic        rsp_ready    [N];
    logic        rsp_valid    [N];
    logic        rsp_special  [N];
    logic        busy         [N];
    logic        adder_op     [N];
    logic [31:0] adder_a      [N];
    logic [31:0] adder_b      [N];
    logic [31:0] adder_result [N];
    logic [31:0] rsp_result   [N];
    logic [2:0]  rsp_flags    [N];

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q [N][$];
    vec_t tbl [14];

    // Stand-in adder: knows the correct IEEE result for the few normal-path pairs used
    function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({a, b, op})
            {32'h3F80_0000, 32'h4000_0000, 1'b0}: return 32'h4040_0000;
            {32'h4040_0000, 32'h3F80_0000, 1'b1}: return 32'h4000_0000;
            {32'h3F80_0000, 32'h3F80_0000, 1'b1}: return 32'h0000_0000;
            {32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0}: return 32'h7F80_0000;
            {32'h0000_0001, 32'h0000_0001, 1'b0}: return 32'h0000_0002;
            {32'hC000_0000, 32'h3F80_0000, 1'b0}: return 32'hBF80_0000;
            default:                              return 32'hDEAD_BEEF;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        fp_addsub_req_ctrl #(
            .WIDTH  (32),
            .LATENCY(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_a       (req_a),
            .req_b       (req_b),
            .req_op      (req_op),
            .adder_a     (adder_a[g]),
            .adder_b     (adder_b[g]),
            .adder_op    (adder_op[g]),
            .adder_result(adder_result[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_result  (rsp_result[g]),
            .rsp_special (rsp_special[g]),
            .busy        (busy[g])
`ifdef FP_EXC_FLAGS_EN
            ,
            .rsp_flags   (rsp_flags[g])
`endif
        );
        assign adder_result[g] = stub_add(adder_a[g], adder_b[g], adder_op[g]);
`ifndef FP_EXC_FLAGS_EN
        assign rsp_flags[g] = 3'b000;
`endif
    end

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake seen at the negedge completes on the next posedge
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            for (int g = 0; g < N; g++) begin
                if (rsp_valid[g] && rsp_ready[g]) begin
                    if (sb_q[g].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_rsp dut%0d: got %h want no response", g, rsp_result[g]);
                    end else begin
                        e = sb_q[g].pop_front();
                        check($sformatf("rsp_result dut%0d", g), rsp_result[g], e.res);
                        check($sformatf("rsp_special dut%0d", g), {31'b0, rsp_special[g]}, {31'b0, e.special});
`ifdef FP_EXC_FLAGS_EN
                        check($sformatf("rsp_flags dut%0d", g), {29'b0, rsp_flags[g]}, {29'b0, e.flags});
`endif
                    end
                end
            end
        end
    end

    task automatic set_ops(input vec_t v);
        req_a  = v.a;
        req_b  = v.b;
        req_op = v.op;
    endtask

    task automatic push_exp(input int g, input vec_t v);
        exp_t e;
        e.res     = v.res;
        e.special = v.special;
        e.flags   = v.flags;
        sb_q[g].push_back(e);
    endtask

    task automatic wait_idle_all(input string tag);
        bit done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(posedge clk);
            #1;
            done = req_ready[0] && req_ready[1] && req_ready[2];
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got busy after 60 cycles want idle", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_prev;
        time t_now;
        int  lat;
        bit  ok;

        tbl[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 3'b000};
        tbl[1]  = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 3'b000};
        tbl[2]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 3'b001};
        tbl[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b0, 3'b010};
        tbl[4]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 3'b000};
        tbl[5]  = '{32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 1'b0, 3'b000};
        tbl[6]  = '{32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, 3'b100};
        tbl[7]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1, 3'b100};
        tbl[8]  = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1, 3'b000};
        tbl[9]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b1, 3'b000};
        tbl[10] = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b1, 3'b000};
        tbl[11] = '{32'h3F80_0000, 32'hFFC0_0000, 1'b0, 32'h7FC0_0000, 1'b1, 3'b100};
        tbl[12] = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b1, 3'b100};
        tbl[13] = '{32'hFF80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1, 3'b000};

        rst    = 1'b1;
        req_a  = '0;
        req_b  = '0;
        req_op = 1'b0;
        for (int g = 0; g < N; g++) begin
            req_valid[g] = 1'b0;
            rsp_ready[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            check($sformatf("reset rsp_valid dut%0d", g), {31'b0, rsp_valid[g]}, 32'd0);
            check($sformatf("reset busy dut%0d", g), {31'b0, busy[g]}, 32'd0);
            check($sformatf("reset req_ready dut%0d", g), {31'b0, req_ready[g]}, 32'd1);
            check($sformatf("reset adder_a dut%0d", g), adder_a[g], 32'd0);
            check($sformatf("reset rsp_result dut%0d", g), rsp_result[g], 32'd0);
        end
        rst = 1'b0;

        // Vector table on all three latencies at once
        for (int i = 0; i < 14; i++) begin
            set_ops(tbl[i]);
            for (int g = 0; g < N; g++) begin
                push_exp(g, tbl[i]);
                req_valid[g] = 1'b1;
                rsp_ready[g] = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < N; g++) req_valid[g] = 1'b0;
            check($sformatf("vec%0d adder_a", i), adder_a[1], tbl[i].a);
            check($sformatf("vec%0d busy", i), {31'b0, busy[1]}, 32'd1);
            wait_idle_all($sformatf("vec%0d", i));
        end
        for (int g = 0; g < N; g++) rsp_ready[g] = 1'b0;

        // LATENCY=2 timing, then backpressure with a pending request
        set_ops(tbl[0]);
        push_exp(1, tbl[0]);
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("l2 busy after accept", {31'b0, busy[1]}, 32'd1);
        check("l2 rsp_valid after accept", {31'b0, rsp_valid[1]}, 32'd0);
        lat = 0;
        while (!rsp_valid[1] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("l2 latency", 32'(lat), 32'd3);
        check("l2 rsp_special", {31'b0, rsp_special[1]}, 32'd0);
        set_ops(tbl[1]);
        push_exp(1, tbl[1]);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp rsp_result", rsp_result[1], 32'h4040_0000);
            check("bp rsp_valid", {31'b0, rsp_valid[1]}, 32'd1);
            check("bp req_ready", {31'b0, req_ready[1]}, 32'd0);
            check("bp adder_a", adder_a[1], 32'h3F80_0000);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("hs rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        check("hs req_ready", {31'b0, req_ready[1]}, 32'd1);
        check("hs no same-cycle accept", adder_a[1], 32'h3F80_0000);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("hs next accept", adder_a[1], 32'h4040_0000);
        wait_idle_all("bp");
        rsp_ready[1] = 1'b0;

        // Bypass on LATENCY=3 responds right after the accept edge
        set_ops(tbl[6]);
        push_exp(2, tbl[6]);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        check("bypass rsp_valid", {31'b0, rsp_valid[2]}, 32'd1);
        check("bypass rsp_result", rsp_result[2], 32'h7FC0_0000);
        check("bypass rsp_special", {31'b0, rsp_special[2]}, 32'd1);
        rsp_ready[2] = 1'b1;
        wait_idle_all("bypass");

        // Reset in the middle of WAIT on LATENCY=3
        set_ops(tbl[0]);
        push_exp(2, tbl[0]);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        check("midwait busy", {31'b0, busy[2]}, 32'd1);
        #2;
        rst = 1'b1;
        for (int g = 0; g < N; g++) sb_q[g].delete();
        #1;
        check("rst rsp_valid", {31'b0, rsp_valid[2]}, 32'd0);
        check("rst busy", {31'b0, busy[2]}, 32'd0);
        check("rst adder_a", adder_a[2], 32'd0);
        check("rst rsp_result", rsp_result[2], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post rst busy", {31'b0, busy[2]}, 32'd0);
        set_ops(tbl[1]);
        push_exp(2, tbl[1]);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_idle_all("post rst");

        // LATENCY=0 back-to-back with rsp_ready held high
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            set_ops(tbl[k]);
            push_exp(0, tbl[k]);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (req_ready[0]) begin
                    @(posedge clk);
                    t_now = $time;
                    #1;
                    ok = 1'b1;
                end
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b2b accept %0d: got no accept want accept", k);
            end else if (k > 0) begin
                check($sformatf("b2b spacing %0d", k), 32'(t_now - t_prev), 32'd30);
            end
            t_prev = t_now;
        end
        req_valid[0] = 1'b0;
        wait_idle_all("b2b");

        for (int g = 0; g < N; g++)
            check($sformatf("scoreboard drained dut%0d", g), 32'(sb_q[g].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
